// File: rtl/zle_arb_pkg.sv
// Shared encodings and defaults for the zle_arb2 two-source ZLE arbiter.
// Optional per-source/switch statistics are enabled with ZLE_ARB_STATS_EN.
package zle_arb_pkg;

    localparam int W_DEF     = 3;
    localparam int BURST_DEF = 8;
    localparam int CW_DEF    = 4;
    localparam int STATS_W   = 16;

    // The grant output is the state encoding itself.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_GA   = 2'b01,
        ST_GB   = 2'b10
    } state_e;

    typedef enum logic {
        SRC_A = 1'b0,
        SRC_B = 1'b1
    } src_e;

endpackage

// File: rtl/zle_arb2_fsm.sv
// Grant FSM: holds state, burst count, clean flag and last grant; switches only at clean points.
// With ZLE_ARB_STATS_EN defined it also flags GA<->GB direct switches.
module zle_arb2_fsm
    import zle_arb_pkg::*;
#(
    parameter int BURST = BURST_DEF,
    parameter int CW    = CW_DEF
) (
    input  logic   clock,
    input  logic   reset,
    input  logic   a_v_i,
    input  logic   b_v_i,
    input  logic   a_nz_i,
    input  logic   b_nz_i,
    input  logic   z_b_i,
    output state_e state_o,
    output logic   sel_a_o,
    output logic   sel_b_o
`ifdef ZLE_ARB_STATS_EN
    ,
    output logic   sw_o
`endif
);

    localparam logic [CW-1:0] BURST_C = CW'(BURST);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            clean_q, clean_d;
    src_e            last_q, last_d;

    logic            own_v, own_nz, oth_v, xfer, clean_n;
    logic [CW-1:0]   cnt_n;

    // NOTE: every variable gets a default before the case so no path infers a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clean_d = clean_q;
        last_d  = last_q;
        own_v   = 1'b0;
        own_nz  = 1'b0;
        oth_v   = 1'b0;

        unique case (state_q)
            ST_GA: begin
                own_v  = a_v_i;
                own_nz = a_nz_i;
                oth_v  = b_v_i;
            end
            ST_GB: begin
                own_v  = b_v_i;
                own_nz = b_nz_i;
                oth_v  = a_v_i;
            end
            default: ;
        endcase

        xfer    = own_v && !z_b_i;
        cnt_n   = xfer ? ((cnt_q == BURST_C) ? cnt_q : cnt_q + CW'(1)) : cnt_q;
        clean_n = xfer ? own_nz : clean_q;

        unique case (state_q)
            ST_IDLE: begin
                if (a_v_i && (!b_v_i || last_q == SRC_B)) begin
                    state_d = ST_GA;
                end else if (b_v_i) begin
                    state_d = ST_GB;
                end
            end
            ST_GA, ST_GB: begin
                cnt_d   = cnt_n;
                clean_d = clean_n;
                // A dirty run (last token zero) pins the grant regardless of quota.
                if (clean_n && oth_v && (cnt_n == BURST_C || !own_v)) begin
                    state_d = (state_q == ST_GA) ? ST_GB : ST_GA;
                    cnt_d   = '0;
                    last_d  = (state_q == ST_GA) ? SRC_A : SRC_B;
                end else if (clean_n && !own_v && !oth_v) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    last_d  = (state_q == ST_GA) ? SRC_A : SRC_B;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            clean_q <= 1'b1;
            last_q  <= SRC_B;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
            last_q  <= last_d;
        end
    end

    assign state_o = state_q;
    assign sel_a_o = (state_q == ST_GA);
    assign sel_b_o = (state_q == ST_GB);

`ifdef ZLE_ARB_STATS_EN
    assign sw_o = ((state_q == ST_GA) && (state_d == ST_GB)) ||
                  ((state_q == ST_GB) && (state_d == ST_GA));
`endif

endmodule

// File: rtl/zle_arb2.sv
// Two-source round-robin arbiter feeding one ZLE encoder; grant moves only at clean token boundaries.
// Define ZLE_ARB_STATS_EN to add per-source token counters and a direct-switch counter.
module zle_arb2
    import zle_arb_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int BURST = BURST_DEF,
    parameter int CW    = CW_DEF
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] a_d,
    input  logic         a_v,
    output logic         a_b,
    input  logic [W-1:0] b_d,
    input  logic         b_v,
    output logic         b_b,
    output logic [W-1:0] z_d,
    output logic         z_v,
    input  logic         z_b,
    output logic [1:0]   gnt
`ifdef ZLE_ARB_STATS_EN
    ,
    output logic [STATS_W-1:0] a_cnt,
    output logic [STATS_W-1:0] b_cnt,
    output logic [STATS_W-1:0] sw_cnt
`endif
);

    state_e state;
    logic   sel_a, sel_b;
`ifdef ZLE_ARB_STATS_EN
    logic   sw;
`endif

    zle_arb2_fsm #(
        .BURST (BURST),
        .CW    (CW)
    ) u_fsm (
        .clock   (clock),
        .reset   (reset),
        .a_v_i   (a_v),
        .b_v_i   (b_v),
        .a_nz_i  (a_d != '0),
        .b_nz_i  (b_d != '0),
        .z_b_i   (z_b),
        .state_o (state),
        .sel_a_o (sel_a),
        .sel_b_o (sel_b)
`ifdef ZLE_ARB_STATS_EN
        ,
        .sw_o    (sw)
`endif
    );

    assign gnt = state;

    always_comb begin
        z_d = '0;
        z_v = 1'b0;
        a_b = 1'b1;
        b_b = 1'b1;
        if (sel_a) begin
            z_d = a_d;
            z_v = a_v;
            a_b = z_b;
        end else if (sel_b) begin
            z_d = b_d;
            z_v = b_v;
            b_b = z_b;
        end
    end

`ifdef ZLE_ARB_STATS_EN
    logic [STATS_W-1:0] a_cnt_q, b_cnt_q, sw_cnt_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            a_cnt_q  <= '0;
            b_cnt_q  <= '0;
            sw_cnt_q <= '0;
        end else begin
            if (a_v && !a_b) a_cnt_q  <= a_cnt_q + STATS_W'(1);
            if (b_v && !b_b) b_cnt_q  <= b_cnt_q + STATS_W'(1);
            if (sw)          sw_cnt_q <= sw_cnt_q + STATS_W'(1);
        end
    end

    assign a_cnt  = a_cnt_q;
    assign b_cnt  = b_cnt_q;
    assign sw_cnt = sw_cnt_q;
`endif

endmodule

// File: tb/tb_zle_arb2.sv
// Directed self-checking bench for zle_arb2: reset, quota switch, clean hold, stall, idle/tie, mid-run reset.
// Stats checks are compiled in when ZLE_ARB_STATS_EN is defined.
module tb_zle_arb2;

    logic       clock;
    logic       reset;
    logic [2:0] a_d, b_d, z_d;
    logic       a_v, b_v, a_b, b_b, z_v, z_b;
    logic [1:0] gnt;
`ifdef ZLE_ARB_STATS_EN
    logic [15:0] a_cnt, b_cnt, sw_cnt;
`endif

    int n_total = 0;
    int n_pass  = 0;

    zle_arb2 dut (
        .clock  (clock),
        .reset  (reset),
        .a_d    (a_d),
        .a_v    (a_v),
        .a_b    (a_b),
        .b_d    (b_d),
        .b_v    (b_v),
        .b_b    (b_b),
        .z_d    (z_d),
        .z_v    (z_v),
        .z_b    (z_b),
        .gnt    (gnt)
`ifdef ZLE_ARB_STATS_EN
        ,
        .a_cnt  (a_cnt),
        .b_cnt  (b_cnt),
        .sw_cnt (sw_cnt)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present one token from the source expected to hold the grant and let it transfer.
    task automatic send(input logic [1:0] g, input logic [2:0] d);
        if (g == 2'b01) a_d = d;
        else            b_d = d;
        #1;
        check("gnt", gnt, g);
        check("z_v", z_v, 1);
        check("z_d", z_d, d);
        check("a_b", a_b, (g == 2'b01) ? 1'b0 : 1'b1);
        check("b_b", b_b, (g == 2'b10) ? 1'b0 : 1'b1);
        tick();
    endtask

    initial begin
        reset = 1'b1;
        a_v   = 1'b1;
        b_v   = 1'b1;
        a_d   = 3'd1;
        b_d   = 3'd2;
        z_b   = 1'b0;

        // Reset held two cycles with both sources requesting.
        repeat (2) tick();
        check("rst_gnt", gnt, 2'b00);
        check("rst_a_b", a_b, 1);
        check("rst_b_b", b_b, 1);
        check("rst_z_v", z_v, 0);
        check("rst_z_d", z_d, 0);

        reset = 1'b0;
        #1;
        check("arb_cycle_gnt", gnt, 2'b00);
        check("arb_cycle_z_v", z_v, 0);
        tick();

        // Quota switch: 8 nonzero A tokens then straight to B.
        for (int i = 0; i < 8; i++) send(2'b01, 3'((i % 7) + 1));
        check("quota_sw_gnt", gnt, 2'b10);
        for (int i = 0; i < 8; i++) send(2'b10, 3'((i % 7) + 1));
        check("b_quota_gnt", gnt, 2'b01);

        // Clean hold: zero tokens past the quota keep A granted until a nonzero arrives.
        for (int i = 0; i < 6; i++) send(2'b01, 3'(i + 1));
        send(2'b01, 3'd3);
        send(2'b01, 3'd0);
        check("hold_cnt_sat", dut.u_fsm.cnt_q, 8);
        check("hold_clean", dut.u_fsm.clean_q, 0);
        send(2'b01, 3'd0);
        send(2'b01, 3'd0);
        send(2'b01, 3'd5);
        check("hold_release_gnt", gnt, 2'b10);
        for (int i = 0; i < 8; i++) send(2'b10, 3'd4);

        // Back-pressure: 3 tokens, 5 stalled cycles, then 5 more tokens complete the burst.
        for (int i = 0; i < 3; i++) send(2'b01, 3'd6);
        z_b = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("stall_gnt", gnt, 2'b01);
            check("stall_a_b", a_b, 1);
            check("stall_cnt", dut.u_fsm.cnt_q, 3);
            tick();
        end
        z_b = 1'b0;
        for (int i = 0; i < 4; i++) send(2'b01, 3'd7);
        check("stall_pre_sw_gnt", gnt, 2'b01);
        send(2'b01, 3'd2);
        check("stall_sw_gnt", gnt, 2'b10);
        for (int i = 0; i < 8; i++) send(2'b10, 3'd1);

        // Idle: both drop after a clean A token, then a tie goes to B (last=A).
        send(2'b01, 3'd1);
        send(2'b01, 3'd2);
        a_v = 1'b0;
        b_v = 1'b0;
        #1;
        check("drop_gnt", gnt, 2'b01);
        check("drop_z_v", z_v, 0);
        tick();
        check("idle_gnt", gnt, 2'b00);
        check("idle_a_b", a_b, 1);
        check("idle_b_b", b_b, 1);
        a_v = 1'b1;
        b_v = 1'b1;
        #1;
        check("tie_idle_z_v", z_v, 0);
        tick();
        check("tie_gnt", gnt, 2'b10);

        // Mid-run reset while the granted run is dirty.
        send(2'b10, 3'd0);
        check("pre_rst_clean", dut.u_fsm.clean_q, 0);
`ifdef ZLE_ARB_STATS_EN
        check("stat_a_cnt", a_cnt, 29);
        check("stat_b_cnt", b_cnt, 25);
        check("stat_sw_cnt", sw_cnt, 6);
`endif
        reset = 1'b1;
        tick();
        check("midrst_gnt", gnt, 2'b00);
        check("midrst_z_v", z_v, 0);
        check("midrst_a_b", a_b, 1);
        check("midrst_b_b", b_b, 1);
        check("midrst_cnt", dut.u_fsm.cnt_q, 0);
        check("midrst_clean", dut.u_fsm.clean_q, 1);
`ifdef ZLE_ARB_STATS_EN
        check("midrst_a_cnt", a_cnt, 0);
        check("midrst_b_cnt", b_cnt, 0);
        check("midrst_sw_cnt", sw_cnt, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
